imem_loader: RTL and testbench

- Byte-stream program loader that writes instruction words into the instruction memory's write port.
- Sits between a host byte source (UART receiver / debug bridge) and the IMEM write port.
- Assembles little-endian bytes into DATA_WIDTH-bit words, writes them at auto-incrementing word addresses, and holds the core while loading.
- The instruction memory's asynchronous read side is untouched; this block is the writer for that array.

---
 rtl/imem_pkg.sv | 14 +
 rtl/imem_loader_byte_packer.sv | 36 +++
 rtl/imem_loader.sv | 106 ++++++++++
 tb/tb_imem_loader.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory loader: default geometry and FSM state encoding.
package imem_pkg;
    localparam int DATA_WIDTH_DFLT = 32;
    localparam int MEM_DEPTH_DFLT  = 1024;
    localparam int BYTES_PER_WORD  = DATA_WIDTH_DFLT / 8;
    localparam int ADDR_W          = $clog2(MEM_DEPTH_DFLT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } ld_state_t;
endpackage

// File: rtl/imem_loader_byte_packer.sv
// Little-endian byte-to-word assembler: one lane per byte, unfilled lanes stay zero after a clear.
module byte_packer
    import imem_pkg::*;
#(
    parameter int NUM_LANES = BYTES_PER_WORD
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clr,
    input  logic                      acc,
    input  logic [7:0]                data,
    input  logic                      last,
    output logic [NUM_LANES-1:0][7:0] word,
    output logic                      word_valid
);
    localparam int LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

    logic [LW-1:0] lane;

    // Asserted on the accept that completes a word, either by filling the top lane or by s_last.
    assign word_valid = acc && (last || (lane == LW'(NUM_LANES - 1)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lane <= '0;
            word <= '0;
        end else if (clr) begin
            lane <= '0;
            word <= '0;
        end else if (acc) begin
            lane <= word_valid ? '0 : lane + 1'b1;
            for (int i = 0; i < NUM_LANES; i++)
                if (lane == LW'(i)) word[i] <= data;
        end
    end
endmodule

// File: rtl/imem_loader.sv
// Byte-stream program loader: packs bytes into words and writes them to IMEM at incrementing addresses.
module imem_loader
    import imem_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DFLT,
    parameter int MEM_DEPTH  = MEM_DEPTH_DFLT,
    parameter int BASE_ADDR  = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic [7:0]                   s_data,
    input  logic                         s_last,
    output logic                         we,
    output logic [$clog2(MEM_DEPTH)-1:0] waddr,
    output logic [DATA_WIDTH-1:0]        wdata,
    output logic                         busy,
    output logic                         done,
    output logic                         err_overflow,
    output logic [$clog2(MEM_DEPTH):0]   word_count
);
    localparam int NL = DATA_WIDTH / 8;
    localparam int AW = $clog2(MEM_DEPTH);

    ld_state_t           state, state_nx;
    logic                arm, hs, full, acc, clr;
    logic                word_valid, word_last;
    logic [NL-1:0][7:0]  word;
    logic [AW+1:0]       fill;

    // Memory is exhausted once the next write would land past the last word.
    assign fill = (AW+2)'(word_count) + (AW+2)'(BASE_ADDR);
    assign full = fill >= (AW+2)'(MEM_DEPTH);
    assign arm  = start && (state == IDLE || state == DONE);
    assign hs   = s_valid && s_ready;
    assign acc  = hs && !full;
    assign clr  = arm || (state == WRITE);

    byte_packer #(.NUM_LANES(NL)) u_packer (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .acc        (acc),
        .data       (s_data),
        .last       (s_last),
        .word       (word),
        .word_valid (word_valid)
    );

    assign wdata = word;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE: if (start) state_nx = RECV;
            RECV: begin
                if (hs && full && s_last) state_nx = DONE;
                else if (word_valid)      state_nx = WRITE;
            end
            WRITE:   state_nx = word_last ? DONE : RECV;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        s_ready = 1'b0;
        we      = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        case (state)
            RECV:  begin s_ready = 1'b1; busy = 1'b1; end
            WRITE: begin we = 1'b1;      busy = 1'b1; end
            DONE:  done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            waddr        <= AW'(BASE_ADDR);
            word_count   <= '0;
            err_overflow <= 1'b0;
            word_last    <= 1'b0;
        end else if (arm) begin
            waddr        <= AW'(BASE_ADDR);
            word_count   <= '0;
            err_overflow <= 1'b0;
            word_last    <= 1'b0;
        end else begin
            if (word_valid) word_last <= s_last;
            if (hs && full) err_overflow <= 1'b1;
            if (state == WRITE) begin
                word_count <= word_count + 1'b1;
                // Hold at the top word rather than wrap back over the image.
                if (waddr != AW'(MEM_DEPTH - 1)) waddr <= waddr + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a default-size instance plus a 4-word instance for overflow.
module tb_imem_loader;
    logic clk = 1'b0, rst = 1'b0, start = 1'b0, sel = 1'b0;
    logic s_valid = 1'b0, s_last = 1'b0;
    logic [7:0] s_data = 8'h00;

    always #5 clk = ~clk;

    logic        rdy0, we0, busy0, done0, err0;
    logic [9:0]  waddr0;
    logic [31:0] wdata0;
    logic [10:0] wc0;
    logic        rdy1, we1, busy1, done1, err1;
    logic [1:0]  waddr1;
    logic [31:0] wdata1;
    logic [2:0]  wc1;

    imem_loader u_dut0 (
        .clk(clk), .rst(rst), .start(start && !sel), .s_valid(s_valid && !sel), .s_ready(rdy0),
        .s_data(s_data), .s_last(s_last), .we(we0), .waddr(waddr0), .wdata(wdata0),
        .busy(busy0), .done(done0), .err_overflow(err0), .word_count(wc0)
    );

    imem_loader #(.DATA_WIDTH(32), .MEM_DEPTH(4), .BASE_ADDR(0)) u_dut1 (
        .clk(clk), .rst(rst), .start(start && sel), .s_valid(s_valid && sel), .s_ready(rdy1),
        .s_data(s_data), .s_last(s_last), .we(we1), .waddr(waddr1), .wdata(wdata1),
        .busy(busy1), .done(done1), .err_overflow(err1), .word_count(wc1)
    );

    logic        rdy_m, we_m, busy_m, done_m, err_m;
    logic [9:0]  waddr_m;
    logic [31:0] wdata_m;
    logic [10:0] wc_m;
    assign rdy_m   = sel ? rdy1 : rdy0;
    assign we_m    = sel ? we1 : we0;
    assign busy_m  = sel ? busy1 : busy0;
    assign done_m  = sel ? done1 : done0;
    assign err_m   = sel ? err1 : err0;
    assign waddr_m = sel ? {8'b0, waddr1} : waddr0;
    assign wdata_m = sel ? wdata1 : wdata0;
    assign wc_m    = sel ? {8'b0, wc1} : wc0;

    int n_chk = 0, n_fail = 0;
    int viol = 0, wr_cnt = 0;

    // While busy, s_ready must be exactly the complement of we.
    always @(negedge clk) begin
        if (busy_m && (rdy_m == we_m)) viol++;
        if (we_m) wr_cnt++;
    end

    typedef struct {
        logic        st;
        logic [7:0]  b;
        logic        last;
        logic        ew;
        logic [9:0]  ea;
        logic [31:0] ed;
    } vec_t;
    vec_t tbl[10];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Presents one byte at a negedge and returns at the negedge after its accepting edge.
    task automatic send(input logic [7:0] d, input logic l, input int gap);
        int n = 0;
        s_valid = 1'b0;
        repeat (gap) @(negedge clk);
        s_valid = 1'b1; s_data = d; s_last = l;
        while (!rdy_m && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            n_chk++; n_fail++;
            $display("FAIL hs_timeout: byte %0h not accepted within 50 cycles", d);
        end
        @(negedge clk);
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    task automatic run_table(input int lo, input int hi, input bit gaps, input int inj);
        for (int i = lo; i <= hi; i++) begin
            if (tbl[i].st) pulse_start();
            if (i == inj) pulse_start();
            send(tbl[i].b, tbl[i].last, gaps ? int'($urandom_range(0, 3)) : 0);
            chk($sformatf("vec%0d_we", i), we_m, tbl[i].ew);
            if (tbl[i].ew) begin
                chk($sformatf("vec%0d_waddr", i), waddr_m, tbl[i].ea);
                chk($sformatf("vec%0d_wdata", i), wdata_m, tbl[i].ed);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int w0, v0;
        tbl[0] = '{1'b1, 8'h00, 1'b0, 1'b0, 10'd0, 32'h0};
        tbl[1] = '{1'b0, 8'h01, 1'b0, 1'b0, 10'd0, 32'h0};
        tbl[2] = '{1'b0, 8'h02, 1'b0, 1'b0, 10'd0, 32'h0};
        tbl[3] = '{1'b0, 8'h03, 1'b0, 1'b1, 10'd0, 32'h03020100};
        tbl[4] = '{1'b0, 8'h04, 1'b0, 1'b0, 10'd0, 32'h0};
        tbl[5] = '{1'b0, 8'h05, 1'b0, 1'b0, 10'd0, 32'h0};
        tbl[6] = '{1'b0, 8'h06, 1'b0, 1'b0, 10'd0, 32'h0};
        tbl[7] = '{1'b0, 8'h07, 1'b1, 1'b1, 10'd1, 32'h07060504};
        tbl[8] = '{1'b0, 8'hAA, 1'b0, 1'b0, 10'd0, 32'h0};
        tbl[9] = '{1'b0, 8'hBB, 1'b1, 1'b1, 10'd0, 32'h0000BBAA};

        // Reset values on both instances.
        #1 rst = 1'b1;
        #1;
        chk("rst_outs0", {rdy0, we0, busy0, done0, err0}, 5'b0);
        chk("rst_waddr0", waddr0, 10'd0);
        chk("rst_wdata0", wdata0, 32'd0);
        chk("rst_wc0", wc0, 11'd0);
        chk("rst_outs1", {rdy1, we1, busy1, done1, err1, waddr1, wc1}, 10'b0);
        @(negedge clk) rst = 1'b0;

        // Bytes offered in IDLE are refused.
        s_valid = 1'b1; s_data = 8'h5A;
        @(negedge clk);
        chk("idle_ready", rdy_m, 1'b0);
        @(negedge clk);
        chk("idle_busy", busy_m, 1'b0);
        s_valid = 1'b0;

        // Two full words.
        w0 = wr_cnt; v0 = viol;
        run_table(0, 7, 1'b0, -1);
        @(negedge clk);
        chk("c1_done", done_m, 1'b1);
        chk("c1_busy", busy_m, 1'b0);
        chk("c1_wc", wc_m, 11'd2);
        chk("c1_writes", wr_cnt - w0, 2);

        // Re-arm from DONE, then a zero-padded partial word.
        pulse_start();
        chk("rearm_done", done_m, 1'b0);
        chk("rearm_waddr", waddr_m, 10'd0);
        chk("rearm_wc", wc_m, 11'd0);
        chk("rearm_err", err_m, 1'b0);
        run_table(8, 9, 1'b0, -1);
        @(negedge clk);
        chk("c2_done", done_m, 1'b1);
        chk("c2_wc", wc_m, 11'd1);

        // Valid gaps, plus a start pulse mid-RECV that must be ignored.
        w0 = wr_cnt;
        run_table(0, 7, 1'b1, 2);
        @(negedge clk);
        chk("c3_done", done_m, 1'b1);
        chk("c3_wc", wc_m, 11'd2);
        chk("c3_writes", wr_cnt - w0, 2);
        chk("ready_vs_we", viol - v0, 0);

        // Overflow on the 4-word instance: 20 bytes, last 4 drained.
        sel = 1'b1;
        w0 = wr_cnt;
        pulse_start();
        for (int b = 0; b < 20; b++) begin
            logic ew;
            send(8'(b), b == 19, 0);
            ew = (b % 4 == 3) && (b < 16);
            chk($sformatf("ovf%0d_we", b), we_m, ew);
            if (ew) begin
                chk($sformatf("ovf%0d_waddr", b), waddr_m, 10'(b / 4));
                chk($sformatf("ovf%0d_wdata", b), wdata_m,
                    {8'(b), 8'(b - 1), 8'(b - 2), 8'(b - 3)});
            end
        end
        @(negedge clk);
        chk("ovf_err", err_m, 1'b1);
        chk("ovf_wc", wc_m, 11'd4);
        chk("ovf_done", done_m, 1'b1);
        chk("ovf_waddr_hold", waddr_m, 10'd3);
        chk("ovf_writes", wr_cnt - w0, 4);
        pulse_start();
        chk("ovf_rearm_err", err_m, 1'b0);
        chk("ovf_rearm_wc", wc_m, 11'd0);
        chk("ovf_rearm_done", done_m, 1'b0);
        sel = 1'b0;

        // Reset in the middle of the second word.
        pulse_start();
        for (int b = 0; b < 6; b++) send(8'(b), 1'b0, 0);
        rst = 1'b1;
        #1;
        chk("mid_rst_outs", {rdy0, we0, busy0, done0, err0}, 5'b0);
        chk("mid_rst_waddr", waddr0, 10'd0);
        chk("mid_rst_wdata", wdata0, 32'd0);
        chk("mid_rst_wc", wc0, 11'd0);
        @(negedge clk) rst = 1'b0;
        pulse_start();
        send(8'h11, 1'b0, 0);
        send(8'h22, 1'b0, 0);
        send(8'h33, 1'b0, 0);
        send(8'h44, 1'b1, 0);
        chk("post_rst_we", we_m, 1'b1);
        chk("post_rst_waddr", waddr_m, 10'd0);
        chk("post_rst_wdata", wdata_m, 32'h44332211);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
